// File: rtl/xosera_reboot_ctrl.sv
// Keyed, bus-quiet-gated sequencer driving the iCE40 SB_WARMBOOT BOOT/S1:S0 pins.
// Define RECONFIG_VBLANK_EN to additionally require vblank_i before committing.
module xosera_reboot_ctrl #(
  parameter logic [7:0] KEY1        = 8'h52,
  parameter logic [7:0] KEY2        = 8'h42,
  parameter int         TIMEOUT_CYC = 65536,
  parameter int         QUIET_CYC   = 16,
  parameter int         SETUP_CYC   = 4
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       cmd_wr_i,
  input  logic [7:0] cmd_data_i,
  input  logic       bus_cs_n_i,
  input  logic       vblank_i,
  output logic       boot_o,
  output logic [1:0] boot_select_o,
  output logic       busy_o,
  output logic       err_o,
  output logic [2:0] state_o
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int QW = (QUIET_CYC > 2) ? $clog2(QUIET_CYC) : 1;
  localparam int SW = (SETUP_CYC > 2) ? $clog2(SETUP_CYC) : 1;

  // Timeout fires on the edge where the counter would step onto TIMEOUT_CYC-1.
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 2);
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYC - 1);
  localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    KEY1_OK    = 3'd1,
    ARMED      = 3'd2,
    WAIT_QUIET = 3'd3,
    SETUP      = 3'd4,
    FIRE       = 3'd5
  } state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [QW-1:0]   quiet_reg, quiet_next;
  logic [SW-1:0]   setup_reg, setup_next;
  logic            err_reg, err_next;
  logic [1:0]      sel_reg, sel_next;
  logic            boot_reg, boot_next;
  logic            quiet;

`ifdef RECONFIG_VBLANK_EN
  assign quiet = bus_cs_n_i & vblank_i;
`else
  logic unused_vblank;
  assign unused_vblank = vblank_i;
  assign quiet         = bus_cs_n_i;
`endif

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      quiet_reg <= '0;
      setup_reg <= '0;
      err_reg   <= 1'b0;
      sel_reg   <= 2'b00;
      boot_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      quiet_reg <= quiet_next;
      setup_reg <= setup_next;
      err_reg   <= err_next;
      sel_reg   <= sel_next;
      boot_reg  <= boot_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = '0;
    quiet_next = '0;
    setup_next = '0;
    err_next   = err_reg;
    sel_next   = sel_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_wr_i) begin
          if (cmd_data_i == KEY1) begin
            state_next = KEY1_OK;
            err_next   = 1'b0;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      KEY1_OK, ARMED: begin
        // A byte on the timeout cycle wins over the timeout.
        if (cmd_wr_i) begin
          if (state_reg == KEY1_OK && cmd_data_i == KEY2) begin
            state_next = ARMED;
          end else if (state_reg == ARMED && cmd_data_i[7:2] == 6'b100000) begin
            state_next = WAIT_QUIET;
            sel_next   = cmd_data_i[1:0];
          end else begin
            state_next = IDLE;
            err_next   = 1'b1;
          end
        end else if (timer_reg == TIMER_LAST) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      WAIT_QUIET: begin
        if (cmd_wr_i && cmd_data_i == 8'h00) begin
          state_next = IDLE;
        end else if (quiet) begin
          if (quiet_reg == QUIET_LAST) begin
            state_next = SETUP;
          end else begin
            quiet_next = quiet_reg + 1'b1;
          end
        end
      end
      SETUP: begin
        if (setup_reg == SETUP_LAST) begin
          state_next = FIRE;
        end else begin
          setup_next = setup_reg + 1'b1;
        end
      end
      FIRE: begin
        state_next = FIRE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    boot_next = (state_next == FIRE);
  end

  assign boot_o        = boot_reg;
  assign boot_select_o = sel_reg;
  assign busy_o        = (state_reg != IDLE);
  assign err_o         = err_reg;
  assign state_o       = state_reg;

endmodule
